// File: rtl/alu32_registered_if.sv
// Operand/result bundle for the registered 32-bit ALU.
// Handshake: there is none. The ALU accepts a, b and aluOp on every rising
// edge of clk, and r/c32/Z/V show that operation's result after that same
// edge. The master keeps its inputs stable across the edge. There is no
// valid/ready pair, because a result is produced every cycle.
interface alu32_registered_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  aluOp;
  logic [31:0] r;
  logic        c32;
  logic        Z;
  logic        V;

  // The datapath side drives the operands and opcode, and it receives the flags.
  modport master (
    output a, b, aluOp,
    input  r, c32, Z, V
  );

  // The ALU side samples the operands and drives the registered results.
  modport slave (
    input  a, b, aluOp,
    output r, c32, Z, V
  );
endinterface

// File: rtl/alu32_registered.sv
// 32-bit integer ALU with registered outputs. It supports AND, OR, ADD,
// SUB and signed SLT. Every output appears one clock after its inputs are sampled.
module alu32_registered (
  input  logic              clk,
  input  logic              reset,
  alu32_registered_if.slave bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic        do_sub;
  logic [31:0] b_in;
  logic [32:0] sum33;
  logic [31:0] sum;
  logic        carry;
  logic        v_add;
  logic        v_sub;
  logic        lt;

  logic [31:0] r_next;
  logic        c_next;
  logic        z_next;
  logic        v_next;

  // Shared adder: SUB and SLT both compute a + ~b + 1, so a single adder serves all arithmetic.
  always_comb begin
    do_sub = (bus.aluOp == OP_SUB) || (bus.aluOp == OP_SLT);
    b_in   = do_sub ? ~bus.b : bus.b;
    sum33  = {1'b0, bus.a} + {1'b0, b_in} + {32'b0, do_sub};
    sum    = sum33[31:0];
    carry  = sum33[32];
    // Overflow is defined on the original operand b, not on the inverted one.
    v_add  = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
    v_sub  = (bus.a[31] != bus.b[31]) && (sum[31] != bus.a[31]);
    // The sign of the difference gives the wrong answer when the subtraction overflows, so it is corrected by Vsub.
    lt     = sum[31] ^ v_sub;
  end

  // Opcode decode. Unused codes yield r = 0, so Z reads as 1 for them.
  always_comb begin
    r_next = 32'd0;
    c_next = 1'b0;
    v_next = 1'b0;
    case (bus.aluOp)
      OP_AND: r_next = bus.a & bus.b;
      OP_OR:  r_next = bus.a | bus.b;
      OP_ADD: begin
        r_next = sum;
        c_next = carry;
        v_next = v_add;
      end
      OP_SUB: begin
        r_next = sum;
        c_next = carry;
        v_next = v_sub;
      end
      OP_SLT: r_next = {31'd0, lt};
      default: begin
        r_next = 32'd0;
        c_next = 1'b0;
        v_next = 1'b0;
      end
    endcase
    z_next = (r_next == 32'd0);
  end

  // Output register. Reset takes priority and leaves Z consistent with r = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.r   <= 32'd0;
      bus.c32 <= 1'b0;
      bus.Z   <= 1'b1;
      bus.V   <= 1'b0;
    end else begin
      bus.r   <= r_next;
      bus.c32 <= c_next;
      bus.Z   <= z_next;
      bus.V   <= v_next;
    end
  end

endmodule

// File: tb/tb_alu32_registered.sv
// Directed table-driven bench for alu32_registered.
module tb_alu32_registered;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam int NV = 24;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu32_registered_if bus();

  alu32_registered dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];   // {r, c32, Z, V}
  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[NV];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rst);
    @(negedge clk);
    reset     = rst;
    bus.aluOp = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  task automatic expect_out(input logic [31:0] r, input logic c,
                            input logic z, input logic v);
    exp_q.push_back({r, c, z, v});
  endtask

  task automatic check(input string name);
    logic [34:0] exp;
    logic [34:0] act;
    @(posedge clk);
    #1;
    n_checks++;
    act = {bus.r, bus.c32, bus.Z, bus.V};
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got r=%h c32=%b Z=%b V=%b",
               name, bus.r, bus.c32, bus.Z, bus.V);
    end else begin
      exp = exp_q.pop_front();
      if (act === exp) n_pass++;
      else
        $display("FAIL %s: got r=%h c32=%b Z=%b V=%b, expected r=%h c32=%b Z=%b V=%b",
                 name, act[34:3], act[2], act[1], act[0],
                 exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    vecs[0]  = '{OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_AND, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_OR,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_ADD, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{OP_SUB, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{OP_SUB, 32'h00000000, 32'h7FFFFFFF, 32'h80000001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_SUB, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{OP_SUB, 32'h00000004, 32'h0000000A, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_SLT, 32'h00000003, 32'h00000008, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_SLT, 32'h00000018, 32'h0000000F, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{OP_SLT, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{OP_SLT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{OP_SLT, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{3'b011, 32'h12345678, 32'h00000009, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[22] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{3'b101, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    bus.aluOp = OP_AND;
    bus.a     = 32'd0;
    bus.b     = 32'd0;

    // Reset state: apply reset for one edge while the inputs would give a nonzero result.
    drive(OP_OR, 32'h0000FFFF, 32'h12340000, 1'b1);
    expect_out(32'd0, 1'b0, 1'b1, 1'b0);
    check("reset_state");

    // Table vectors run back to back, so each result must land exactly one edge after its inputs.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      expect_out(vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].v);
      check($sformatf("vec%0d_op%b", i, vecs[i].op));
    end

    // Reset priority: a nonzero ADD result is followed by reset in the same cycle as another ADD.
    drive(OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    expect_out(32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    check("pre_reset_add");
    drive(OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    expect_out(32'd0, 1'b0, 1'b1, 1'b0);
    check("reset_priority");

    // The ALU recovers on the first edge after reset drops.
    drive(OP_SUB, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    expect_out(32'h00000001, 1'b1, 1'b0, 1'b1);
    check("post_reset_sub");

    // The opcode changes with unchanged operands on consecutive cycles.
    drive(OP_ADD, 32'h00000003, 32'h00000008, 1'b0);
    expect_out(32'h0000000B, 1'b0, 1'b0, 1'b0);
    check("b2b_add");
    drive(OP_SUB, 32'h00000003, 32'h00000008, 1'b0);
    expect_out(32'hFFFFFFFB, 1'b0, 1'b0, 1'b0);
    check("b2b_sub");
    drive(OP_SLT, 32'h00000003, 32'h00000008, 1'b0);
    expect_out(32'h00000001, 1'b0, 1'b0, 1'b0);
    check("b2b_slt");

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
